// File: rtl/banco_registros.sv
// Parametrised register file: one write port, two registered read ports with
// write-to-read bypass, optional hardwired-zero entry 0 and a sequenced bulk clear.
module banco_registros #(
    parameter int N       = 16,
    parameter int A       = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         w,
    input  logic [A-1:0] wsel,
    input  logic [N-1:0] s,
    input  logic         re,
    input  logic [A-1:0] ra,
    input  logic [A-1:0] rb,
    input  logic         clr,
    output logic [N-1:0] qa,
    output logic [N-1:0] qb,
    output logic         busy
);

    localparam int DEPTH = 1 << A;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t       r_state;
    logic [A-1:0] r_cnt;
    logic         r_busy;
    logic [N-1:0] r_mem [DEPTH];
    logic [N-1:0] r_qa;
    logic [N-1:0] r_qb;

    logic         w_wr_ok;
    logic         w_zero_a;
    logic         w_zero_b;
    logic [N-1:0] w_rd_a;
    logic [N-1:0] w_rd_b;

    // A write is taken only in IDLE, never alongside a clear request, never to a hardwired zero.
    assign w_wr_ok  = (r_state == IDLE) && !clr && w && !((ZERO_R0 != 0) && (wsel == '0));
    assign w_zero_a = (ZERO_R0 != 0) && (ra == '0);
    assign w_zero_b = (ZERO_R0 != 0) && (rb == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (!w_zero_a) begin
            w_rd_a = (w_wr_ok && (wsel == ra)) ? s : r_mem[ra];
        end
        if (!w_zero_b) begin
            w_rd_b = (w_wr_ok && (wsel == rb)) ? s : r_mem[rb];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the array is built from flops and must read zero straight out of reset,
    // so it is reset explicitly; this rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wsel] <= s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qa <= '0;
            r_qb <= '0;
        end else if (re) begin
            r_qa <= w_rd_a;
            r_qb <= w_rd_b;
        end
    end

    assign qa   = r_qa;
    assign qb   = r_qb;
    assign busy = r_busy;

endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: drives a normal and a ZERO_R0 instance with the same
// directed vectors and compares both against a behavioural model every cycle.
module tb_banco_registros;

    logic        clk = 1'b0;
    logic        rst;
    logic        w, re, clr;
    logic [3:0]  wsel, ra, rb;
    logic [15:0] s;
    logic [15:0] qa0, qb0, qa1, qb1;
    logic        busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model, index 0 = plain instance, index 1 = hardwired-zero instance.
    logic [15:0] m_mem [2][16];
    logic [15:0] m_qa  [2];
    logic [15:0] m_qb  [2];
    bit          m_busy[2];
    int          m_idx [2];

    always #5 clk = ~clk;

    banco_registros #(.N(16), .A(4), .ZERO_R0(0)) dut0 (
        .clk(clk), .rst(rst), .w(w), .wsel(wsel), .s(s), .re(re), .ra(ra), .rb(rb),
        .clr(clr), .qa(qa0), .qb(qb0), .busy(busy0)
    );

    banco_registros #(.N(16), .A(4), .ZERO_R0(1)) dut1 (
        .clk(clk), .rst(rst), .w(w), .wsel(wsel), .s(s), .re(re), .ra(ra), .rb(rb),
        .clr(clr), .qa(qa1), .qb(qb1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m_mem[d][i] = 16'h0;
            m_qa[d]   = 16'h0;
            m_qb[d]   = 16'h0;
            m_busy[d] = 1'b0;
            m_idx[d]  = 0;
        end
    endtask

    task automatic model_step();
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            acc = !m_busy[d] && !clr && w && !(d == 1 && wsel == 4'd0);
            if (re) begin
                m_qa[d] = (d == 1 && ra == 4'd0) ? 16'h0 : (acc && wsel == ra) ? s : m_mem[d][ra];
                m_qb[d] = (d == 1 && rb == 4'd0) ? 16'h0 : (acc && wsel == rb) ? s : m_mem[d][rb];
            end
            if (m_busy[d]) begin
                m_mem[d][m_idx[d]] = 16'h0;
                m_idx[d]++;
                if (m_idx[d] == 16) begin
                    m_busy[d] = 1'b0;
                    m_idx[d]  = 0;
                end
            end else if (clr) begin
                m_busy[d] = 1'b1;
                m_idx[d]  = 0;
            end else if (acc) begin
                m_mem[d][wsel] = s;
            end
        end
    endtask

    // One clock: model follows the edge, then inputs may change 1 ns after the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("qa0",   qa0,   m_qa[0]);
        check("qb0",   qb0,   m_qb[0]);
        check("busy0", busy0, m_busy[0]);
        check("qa1",   qa1,   m_qa[1]);
        check("qb1",   qb1,   m_qb[1]);
        check("busy1", busy1, m_busy[1]);
    end

    initial begin
        int busy_cnt;
        rst = 1'b1; w = 0; re = 0; clr = 0; wsel = 0; ra = 0; rb = 0; s = 0;
        model_reset();
        #1;
        check("por_qa0", qa0, 16'h0);
        check("por_busy0", busy0, 1'b0);
        cycle();
        rst = 1'b0;
        cycle();

        // Reset then read
        w = 1; wsel = 4'd5; s = 16'hBEEF; re = 1; ra = 4'd5; rb = 4'd15;
        cycle();
        check("beef_bypass", qa0, 16'hBEEF);
        w = 0; re = 0;
        rst = 1'b1; model_reset();
        #1;
        check("async_rst_qa0", qa0, 16'h0);
        check("async_rst_qa1", qa1, 16'h0);
        cycle();
        rst = 1'b0;
        re = 1; ra = 4'd5; rb = 4'd15;
        cycle();
        check("rst_read_qa", qa0, 16'h0);
        check("rst_read_qb", qb0, 16'h0);
        check("rst_read_busy", busy0, 1'b0);

        // Write with bypass, then plain read
        w = 1; wsel = 4'd3; s = 16'h1234; re = 1; ra = 4'd3; rb = 4'd3;
        cycle();
        check("bypass_qa0", qa0, 16'h1234);
        check("bypass_qb0", qb0, 16'h1234);
        check("bypass_qa1", qa1, 16'h1234);
        w = 0;
        cycle();
        check("array_qa0", qa0, 16'h1234);

        // Entry 0 write with same-cycle read
        w = 1; wsel = 4'd0; s = 16'hFFFF; ra = 4'd0; rb = 4'd0;
        cycle();
        check("r0_bypass_z", qa1, 16'h0);
        check("r0_bypass_n", qa0, 16'hFFFF);
        w = 0;
        cycle();
        check("r0_read_z", qa1, 16'h0);
        check("r0_read_n", qb0, 16'hFFFF);

        // Fill, then bulk clear
        re = 0;
        for (int i = 0; i < 16; i++) begin
            w = 1; wsel = 4'(i); s = 16'hA5A5 + 16'(i);
            cycle();
        end
        w = 0;
        clr = 1;
        cycle();
        clr = 0;
        busy_cnt = busy0 ? 1 : 0;
        check("busy_rise", busy0, 1'b1);
        for (int j = 1; j <= 18; j++) begin
            w = 0; re = 0;
            if (j == 1)  begin w = 1; wsel = 4'd2; s = 16'hDEAD; end
            if (j == 2)  begin re = 1; ra = 4'd2; rb = 4'd15; end
            if (j == 8)  begin re = 1; ra = 4'd15; rb = 4'd1; end
            if (j == 17) begin w = 1; wsel = 4'd4; s = 16'h1111; end
            if (j == 18) begin re = 1; ra = 4'd4; rb = 4'd15; end
            cycle();
            if (busy0) busy_cnt++;
            if (j == 2)  check("clr_w_ignored", qa0, 16'hA5A7);
            if (j == 8)  check("clr_old_e15", qa0, 16'hA5B4);
            if (j == 8)  check("clr_done_e1", qb0, 16'h0);
            if (j == 18) check("post_clr_write", qa0, 16'h1111);
            if (j == 18) check("post_clr_e15", qb0, 16'h0);
        end
        check("busy_len", busy_cnt, 16);

        // clr and w together: clear wins
        clr = 1; w = 1; wsel = 4'd7; s = 16'h00FF; re = 0;
        cycle();
        clr = 0; w = 0; re = 1; ra = 4'd7; rb = 4'd7;
        cycle();
        check("clr_wins_early", qa0, 16'h0);
        re = 0;
        repeat (16) cycle();
        re = 1;
        cycle();
        check("clr_wins_late", qa0, 16'h0);

        // Reset in the middle of a clear
        w = 1; wsel = 4'd9; s = 16'h5A5A; re = 0;
        cycle();
        w = 0; clr = 1;
        cycle();
        clr = 0; re = 1; ra = 4'd9; rb = 4'd9;
        repeat (5) cycle();
        check("mid_busy", busy0, 1'b1);
        check("mid_qa", qa0, 16'h5A5A);
        rst = 1'b1; model_reset();
        #1;
        check("abort_busy0", busy0, 1'b0);
        check("abort_qa0", qa0, 16'h0);
        check("abort_qb0", qb0, 16'h0);
        check("abort_busy1", busy1, 1'b0);
        cycle();
        rst = 1'b0;
        w = 1; wsel = 4'd9; s = 16'hC0DE; re = 0;
        cycle();
        w = 0; re = 1; ra = 4'd9; rb = 4'd3;
        cycle();
        check("after_abort_qa", qa0, 16'hC0DE);
        check("after_abort_qb", qb0, 16'h0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/banco_registros.md
# banco_registros

Parametrised register file, successor to the fixed 16×16 write-only bank in `rtl/memoria`. It has one write port, two synchronous read ports with write-to-read bypass, and an optional hardwired-zero register 0. A sequenced bulk-clear engine zeroes the array one entry per cycle without a global reset. It sits between the instruction decoder (addresses, write enable) and the ALU operand path (qa, qb).

## Interface
- N, 16: data width in bits (≥1).
- A, 4: address width; DEPTH = 2^A entries.
- ZERO_R0, 0: when 1, entry 0 always reads 0 and writes to it are discarded.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- w  in  1  write enable.
- wsel  in  A  write address.
- s  in  N  write data.
- re  in  1  read enable for both read ports.
- ra  in  A  read address, port A.
- rb  in  A  read address, port B.
- clr  in  1  bulk-clear request, sampled on clk.
- qa  out  N  registered read data, port A.
- qb  out  N  registered read data, port B.
- busy  out  1  high while a clear sequence is running.

## Operation
- Reset (rst=1, asynchronous, no clock needed):
  - All DEPTH entries, qa, and qb are 0.
  - busy=0, FSM in IDLE, clear counter cnt=0.
  - Reset asserted during a clear aborts the clear; the array is zero anyway.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on a clock edge with clr=1; cnt←0.
  - CLEAR: each edge writes 0 to entry cnt, then cnt←cnt+1.
  - CLEAR→IDLE on the edge that clears entry DEPTH-1; cnt wraps to 0.
- busy = (state==CLEAR), a registered output.
- Write:
  - In IDLE with clr=0 and w=1: entry[wsel]←s at the edge.
  - If ZERO_R0=1 and wsel=0, the write is discarded.
  - Writes with busy=1 are ignored and not queued.
  - clr=1 and w=1 in the same IDLE cycle: the clear wins and the write is dropped.
- Read:
  - If re=1 at an edge: qa←entry[ra] and qb←entry[rb], using pre-edge array contents.
  - If re=0, qa and qb hold their values.
- Bypass: if a write is accepted on the same edge and wsel==ra, qa←s (same rule for rb/qb).
  - Bypass is suppressed when ZERO_R0=1 and the address is 0; that port gets 0.
- ZERO_R0=1: a read of address 0 always returns 0.
- During CLEAR, reads are allowed and there is no bypass.
  - An entry already cleared reads 0.
  - An entry not yet cleared reads its old value.
- clr while busy=1 is ignored; the running sequence is not restarted.
- Widths: cnt is A bits; DEPTH entries of N bits; no arithmetic on data.

## Timing
- Read latency: 1 cycle. Address presented before edge k; data valid on qa/qb after edge k.
- Write latency: 1 cycle. Data written at edge k is visible on a plain read sampled at edge k+1; through the bypass it is visible at edge k itself.
- Clear, with clr sampled at edge k:
  - busy rises after edge k.
  - Entries 0..DEPTH-1 are cleared at edges k+1..k+DEPTH.
  - busy falls after edge k+DEPTH.
  - busy is high for exactly DEPTH cycles.
  - A write with w=1 at edge k+DEPTH+1 is accepted.
- Reset: all outputs go to 0 asynchronously on rst rising, with no clock edge required.
- First edge after rst falls: normal IDLE behaviour.

## Test plan
- Reset then read: write 0xBEEF to entry 5, pulse rst, read ra=5, rb=15 → qa=0, qb=0, busy=0.
- Write/read and bypass:
  - w=1, wsel=3, s=0x1234, re=1, ra=3, rb=3 on the same edge → qa=qb=0x1234 after that edge.
  - Next edge with w=0 → still 0x1234 from the array.
- ZERO_R0=1 instance: write 0xFFFF to entry 0 with ra=0 in the same cycle → qa=0; a later read of entry 0 → 0.
- Bulk clear (A=4):
  - Fill entries 0..15 with 0xA5A5 + index, pulse clr → busy high exactly 16 cycles.
  - w=1 to entry 2 during busy is ignored.
  - Read entry 15 at edge k+8 → old value 0xA5B4; read entry 15 after busy falls → 0.
- Simultaneous clr and w in IDLE: clr=1, w=1, wsel=7, s=0x00FF → write dropped; entry 7 reads 0 after the clear.
- Reset mid-clear: assert rst at cycle 6 of CLEAR → busy=0 and qa=qb=0 immediately; after release, a write then read of entry 9 works with 1-cycle latency.
